// File: rtl/gamepad_pkg.sv
// rtl/gamepad_pkg.sv - shared widths, absent-pad constant and FSM state encoding
package gamepad_pkg;
  localparam int PAD_BITS = 12;
  localparam int FRAME_BITS = 24;
  localparam logic [PAD_BITS-1:0] PAD_ABSENT = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;
endpackage

// File: rtl/gamepad_tick.sv
// rtl/gamepad_tick.sv - half-period phase tick, pulses on the last cycle of each CLK_DIV window
module gamepad_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);
  logic [7:0] cnt;

  assign tick = run && (cnt == 8'(CLK_DIV - 1));

  // Wraps straight to 0 so consecutive phases and states abut with no filler cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (!run || tick) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: rtl/gamepad_pmod_tx.sv
// rtl/gamepad_pmod_tx.sv - serialises two 12-bit pads to the PMOD gamepad receiver
// Macro GAMEPAD_TX_SECOND_PAD_EN: take the upper frame bits from pad1 instead of 12'hFFF.
module gamepad_pmod_tx
  import gamepad_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int FRAME_GAP = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PAD_BITS-1:0] pad0,
  input  logic [PAD_BITS-1:0] pad1,
  output logic                pmod_clk,
  output logic                pmod_data,
  output logic                pmod_latch,
  output logic                busy,
  output logic                frame_done
);
  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] LOAD  = ST_LOAD;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] LATCH = ST_LATCH;
  localparam logic [15:0] GAP_MAX = 16'(FRAME_GAP);

  logic [1:0]            state;
  logic [15:0]           gap;
  logic [4:0]            bit_idx;
  logic                  phase;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] word;
  logic                  tick;
  logic                  run;
  logic                  gap_ready;

`ifdef GAMEPAD_TX_SECOND_PAD_EN
  assign word = {pad1, pad0};
`else
  logic unused_pad1;
  assign unused_pad1 = ^pad1;
  assign word = {PAD_ABSENT, pad0};
`endif

  // True on the last idle cycle of the gap, so LOAD follows exactly FRAME_GAP idle cycles.
  assign gap_ready = ({1'b0, gap} + 17'd1) >= 17'(FRAME_GAP);
  assign run = (state == SHIFT) || (state == LATCH);

  gamepad_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick)
  );

  assign pmod_clk   = (state == SHIFT) && phase;
  assign pmod_data  = (state == SHIFT) && shreg[bit_idx];
  assign pmod_latch = (state == LATCH);
  assign busy       = (state != IDLE);
  assign frame_done = (state == LATCH) && tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap     <= 16'd0;
      bit_idx <= 5'd0;
      phase   <= 1'b0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && gap_ready) begin
            state <= LOAD;
          end else if (gap != GAP_MAX) begin
            gap <= gap + 16'd1;
          end
        end
        LOAD: begin
          shreg   <= word;
          bit_idx <= 5'(FRAME_BITS - 1);
          phase   <= 1'b0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              // Index only moves on low-phase entry, keeping data stable across the rising edge.
              phase <= 1'b0;
              if (bit_idx == 5'd0) begin
                state <= LATCH;
              end else begin
                bit_idx <= bit_idx - 5'd1;
              end
            end
          end
        end
        LATCH: begin
          if (tick) begin
            gap <= 16'd0;
            if (FRAME_GAP == 0 && en) begin
              state <= LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// tb/tb_gamepad_pmod_tx.sv - directed/random bench with receiver-side reference model
module tb_gamepad_pmod_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0, en = 1'b0;
  logic [11:0] pad0 = 12'h0, pad1 = 12'h0;
  logic pmod_clk, pmod_data, pmod_latch, busy, frame_done;

  logic rst_nf = 1'b0, en_f = 1'b0;
  logic [11:0] pad0_f = 12'h0, pad1_f = 12'h0;
  logic pmod_clk_f, pmod_data_f, pmod_latch_f, busy_f, frame_done_f;

  int total = 0, bad = 0, cyc = 0;

  gamepad_pmod_tx #(.CLK_DIV(4), .FRAME_GAP(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pad0(pad0), .pad1(pad1),
    .pmod_clk(pmod_clk), .pmod_data(pmod_data), .pmod_latch(pmod_latch),
    .busy(busy), .frame_done(frame_done)
  );

  gamepad_pmod_tx #(.CLK_DIV(1), .FRAME_GAP(0)) dut_fast (
    .clk(clk), .rst_n(rst_nf), .en(en_f), .pad0(pad0_f), .pad1(pad1_f),
    .pmod_clk(pmod_clk_f), .pmod_data(pmod_data_f), .pmod_latch(pmod_latch_f),
    .busy(busy_f), .frame_done(frame_done_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [23:0] expect_word(input logic [11:0] a0, input logic [11:0] a1);
`ifdef GAMEPAD_TX_SECOND_PAD_EN
    return {a1, a0};
`else
    return {12'hFFF, a0};
`endif
  endfunction

  // Receiver model for the slow instance: shift in on every pmod_clk rise, capture at latch rise.
  logic [23:0] m_sh = 0;
  int m_bits = 0, m_rises = 0, m_lat_len = 0, m_latches = 0, m_viol = 0, m_dones = 0;
  logic m_pc = 0, m_pd = 0, m_pl = 0;
  logic [23:0] cap_q[$];
  int nb_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_sh = 0;
      m_bits = 0;
      m_lat_len = 0;
    end
    if (pmod_clk && !m_pc) begin
      m_sh = {m_sh[22:0], pmod_data};
      m_bits++;
      m_rises++;
    end
    if (pmod_clk && m_pc && (pmod_data !== m_pd)) m_viol++;
    if (pmod_latch) begin
      if (!m_pl) begin
        cap_q.push_back(m_sh);
        nb_q.push_back(m_bits);
        m_bits = 0;
        m_lat_len = 0;
        m_latches++;
      end
      m_lat_len++;
    end
    if (frame_done) m_dones++;
    m_pc = pmod_clk;
    m_pd = pmod_data;
    m_pl = pmod_latch;
  end

  // Fast instance model: every frame must be 50 cycles apart, 24 bits, correct word, never idle.
  logic [23:0] f_sh = 0, f_exp = 0;
  int f_bits = 0, f_frames = 0, f_bad_word = 0, f_bad_bits = 0, f_bad_int = 0, f_idle = 0, f_last = -1;
  logic f_pc = 0;

  always @(negedge clk) begin
    if (rst_nf) begin
      if (pmod_clk_f && !f_pc) begin
        f_sh = {f_sh[22:0], pmod_data_f};
        f_bits++;
      end
      if (frame_done_f) begin
        f_frames++;
        if (f_sh !== f_exp) f_bad_word++;
        if (f_bits != 24) f_bad_bits++;
        if (f_last >= 0 && (cyc - f_last) != 50) f_bad_int++;
        f_last = cyc;
        f_bits = 0;
      end
      if (f_frames > 0 && !busy_f) f_idle++;
    end
    f_pc = pmod_clk_f;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic cycles_to_busy(input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (busy) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_bits(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (m_bits == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [23:0] exp_word);
    check({tag, "_captures"}, cap_q.size(), 1);
    if (cap_q.size() > 0) begin
      check({tag, "_word"}, cap_q.pop_front(), exp_word);
      check({tag, "_bits"}, nb_q.pop_front(), 24);
    end
    check({tag, "_latch_len"}, m_lat_len, 4);
    cap_q.delete();
    nb_q.delete();
  endtask

  initial begin
    logic [23:0] exp_word;
    logic [11:0] tbl0 [2];
    logic [11:0] tbl1 [2];
    int n, last, rises0, lat0, d0;
    bit ok, busy_seen;

    tbl0[0] = 12'hA5C; tbl1[0] = 12'h3F0;
    tbl0[1] = 12'h001; tbl1[1] = 12'h123;

    repeat (3) step();
    check("reset_outputs", {pmod_clk, pmod_data, pmod_latch, busy, frame_done}, 0);
    check("reset_outputs_fast", {pmod_clk_f, pmod_data_f, pmod_latch_f, busy_f, frame_done_f}, 0);

    pad0_f = 12'($urandom);
    pad1_f = 12'($urandom);
    f_exp = expect_word(pad0_f, pad1_f);
    rst_nf = 1'b1;
    en_f = 1'b1;

    pad0 = tbl0[0];
    pad1 = tbl1[0];
    exp_word = expect_word(pad0, pad1);
    en = 1'b1;
    rst_n = 1'b1;
    cycles_to_busy(100, n);
    check("first_load_gap", n, 16);

    last = -1;
    for (int f = 0; f < 5; f++) begin
      wait_done(400, ok);
      check("frame_done_seen", ok, 1);
      check_frame("frame", exp_word);
      if (last >= 0) check("frame_period", cyc - last, 213);
      last = cyc;
      if (f < 1) begin
        pad0 = tbl0[f + 1];
        pad1 = tbl1[f + 1];
      end else begin
        pad0 = 12'($urandom);
        pad1 = 12'($urandom);
      end
      exp_word = expect_word(pad0, pad1);
    end

    // Change pad0 while bit 10 is on the wire: the in-flight frame keeps the snapshot.
    wait_done(400, ok);
    check("pre_mid_done", ok, 1);
    check_frame("pre_mid", exp_word);
    pad0 = 12'h000;
    exp_word = expect_word(12'h000, pad1);
    wait_bits(13, 400, ok);
    check("mid_reach_bit10", ok, 1);
    pad0 = 12'hFFF;
    wait_done(400, ok);
    check("mid_done", ok, 1);
    check_frame("mid_old", exp_word);
    exp_word = expect_word(12'hFFF, pad1);

    // Drop en at bit 5: frame completes, then nothing until en returns.
    wait_bits(18, 400, ok);
    check("en_reach_bit5", ok, 1);
    en = 1'b0;
    wait_done(400, ok);
    check("en_drop_done", ok, 1);
    check_frame("mid_new", exp_word);
    rises0 = m_rises;
    lat0 = m_latches;
    busy_seen = 1'b0;
    repeat (40) begin
      step();
      if (busy) busy_seen = 1'b1;
    end
    check("idle_no_busy", busy_seen, 0);
    check("idle_no_clk", m_rises, rises0);
    check("idle_no_latch", m_latches, lat0);
    pad0 = 12'($urandom);
    pad1 = 12'($urandom);
    exp_word = expect_word(pad0, pad1);
    en = 1'b1;
    cycles_to_busy(40, n);
    check("reenable_load", n, 1);
    wait_done(400, ok);
    check("reenable_done", ok, 1);
    check_frame("reenable", exp_word);

    // Short en drop inside the gap: LOAD still waits out the full gap from latch exit.
    en = 1'b0;
    repeat (5) step();
    pad0 = 12'($urandom);
    pad1 = 12'($urandom);
    exp_word = expect_word(pad0, pad1);
    en = 1'b1;
    cycles_to_busy(40, n);
    check("short_drop_gap", n, 12);
    wait_done(400, ok);
    check("short_drop_done", ok, 1);
    check_frame("short_drop", exp_word);

    // Reset during LATCH.
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (pmod_latch) begin
        ok = 1'b1;
        break;
      end
    end
    check("latch_reached", ok, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_latch_outputs", {pmod_clk, pmod_data, pmod_latch, busy, frame_done}, 0);
    d0 = m_dones;
    repeat (3) step();
    check("rst_no_done", m_dones, d0);
    check("rst_hold_outputs", {pmod_clk, pmod_data, pmod_latch, busy, frame_done}, 0);
    cap_q.delete();
    nb_q.delete();
    pad0 = 12'($urandom);
    pad1 = 12'($urandom);
    exp_word = expect_word(pad0, pad1);
    rst_n = 1'b1;
    cycles_to_busy(100, n);
    check("post_reset_gap", n, 16);
    wait_done(400, ok);
    check("post_reset_done", ok, 1);
    check_frame("post_reset", exp_word);

    check("data_stable_high", m_viol, 0);
    check("fast_frames_min", 32'(f_frames >= 20), 1);
    check("fast_word_errors", f_bad_word, 0);
    check("fast_bit_errors", f_bad_bits, 0);
    check("fast_period_errors", f_bad_int, 0);
    check("fast_idle_cycles", f_idle, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
